// File: rtl/countdown_timer_gen2_if.sv
`default_nettype none
// ============================================================================
// countdown_timer_gen2_if : raw key inputs plus display/status outputs
// Revision: 1.0
// ============================================================================
interface countdown_timer_gen2_if #(
    parameter int N_DIG = 6
);
    logic                 ke;
    logic                 ku;
    logic                 kd;
    logic                 kl;
    logic                 kr;
    logic [N_DIG-1:0]     sel;
    logic [7:0]           led;
    logic                 alarm;
    logic [2:0]           state_o;
    logic [4*N_DIG-1:0]   bcd_o;

    modport master (
        output ke, ku, kd, kl, kr,
        input  sel, led, alarm, state_o, bcd_o
    );

    modport slave (
        input  ke, ku, kd, kl, kr,
        output sel, led, alarm, state_o, bcd_o
    );
endinterface
`default_nettype wire

// File: rtl/countdown_timer_gen2.sv
`default_nettype none
// ============================================================================
// countdown_timer_gen2 : N-digit BCD countdown timer, five debounced keys,
//                        multiplexed 7-segment display, active-low alarm
// Revision: 1.0
// ============================================================================
module countdown_timer_gen2 #(
    parameter int N_DIG     = 6,
    parameter int DEB_CYC   = 1000000,
    parameter int TICK_CYC  = 50000000,
    parameter int SCAN_CYC  = 1000000,
    parameter int BLINK_CYC = 25000000,
    parameter int SEXA      = 0
) (
    input  wire logic             clkin,
    input  wire logic             rst_n,
    countdown_timer_gen2_if.slave bus
);
    localparam int CW = (N_DIG > 1) ? $clog2(N_DIG) : 1;
    localparam int DW = $clog2(DEB_CYC + 1);
    localparam int TW = $clog2(TICK_CYC + 1);
    localparam int SW = $clog2(SCAN_CYC + 1);
    localparam int BW = $clog2(BLINK_CYC + 1);
    localparam logic [CW-1:0] C_LAST       = CW'(N_DIG - 1);
    localparam logic [DW-1:0] C_DEB        = DW'(DEB_CYC);
    localparam logic [TW-1:0] C_TICK_LAST  = TW'(TICK_CYC - 1);
    localparam logic [SW-1:0] C_SCAN_LAST  = SW'(SCAN_CYC - 1);
    localparam logic [BW-1:0] C_BLINK_LAST = BW'(BLINK_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SET   = 3'd1,
        S_RUN   = 3'd2,
        S_PAUSE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    function automatic logic [3:0] digit_max(input int i);
        return (SEXA != 0 && (i % 2) == 1) ? 4'd5 : 4'd9;
    endfunction

    function automatic logic [7:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 8'hC0;
            4'd1:    return 8'hF9;
            4'd2:    return 8'hA4;
            4'd3:    return 8'hB0;
            4'd4:    return 8'h99;
            4'd5:    return 8'h92;
            4'd6:    return 8'h82;
            4'd7:    return 8'hF8;
            4'd8:    return 8'h80;
            4'd9:    return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    // Key order: bit0 ke, bit1 ku, bit2 kd, bit3 kr, bit4 kl (also priority order)
    logic [4:0] w_key_raw;
    logic [4:0] r_sync1;
    logic [4:0] r_sync2;
    logic [4:0] w_rel;
    logic       w_ev_e, w_ev_u, w_ev_d, w_ev_r, w_ev_l;

    assign w_key_raw = {bus.kl, bus.kr, bus.kd, bus.ku, bus.ke};

    always_ff @(posedge clkin) begin
        if (!rst_n) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= w_key_raw;
            r_sync2 <= r_sync1;
        end
    end

    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_deb
            logic [DW-1:0] r_cnt;
            always_ff @(posedge clkin) begin
                if (!rst_n || r_sync2[gi]) begin
                    r_cnt <= '0;
                end else if (r_cnt != C_DEB) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
            // Counter is still saturated on the first high cycle, so this fires once per release
            assign w_rel[gi] = r_sync2[gi] && (r_cnt == C_DEB);
        end
    endgenerate

    assign w_ev_e = w_rel[0];
    assign w_ev_u = w_rel[1] && !w_rel[0];
    assign w_ev_d = w_rel[2] && (w_rel[1:0] == 2'b00);
    assign w_ev_r = w_rel[3] && (w_rel[2:0] == 3'b000);
    assign w_ev_l = w_rel[4] && (w_rel[3:0] == 4'b0000);

    state_t               r_state, w_state_nxt;
    logic [4*N_DIG-1:0]   r_count, w_count_nxt;
    logic [4*N_DIG-1:0]   r_preload, w_preload_nxt;
    logic [CW-1:0]        r_cursor, w_cursor_nxt;
    logic [TW-1:0]        r_psc, w_psc_nxt;
    logic [4*N_DIG-1:0]   w_count_dec;
    logic [3:0]           w_cur_dig, w_cur_max, w_dig_inc, w_dig_dec;

    always_comb begin
        logic borrow;
        borrow      = 1'b1;
        w_count_dec = r_count;
        for (int i = 0; i < N_DIG; i++) begin
            if (borrow) begin
                if (r_count[4*i +: 4] == 4'd0) begin
                    w_count_dec[4*i +: 4] = digit_max(i);
                end else begin
                    w_count_dec[4*i +: 4] = r_count[4*i +: 4] - 4'd1;
                    borrow                = 1'b0;
                end
            end
        end
    end

    assign w_cur_dig = r_count[int'(r_cursor)*4 +: 4];
    assign w_cur_max = digit_max(int'(r_cursor));
    assign w_dig_inc = (w_cur_dig == w_cur_max) ? 4'd0 : w_cur_dig + 4'd1;
    assign w_dig_dec = (w_cur_dig == 4'd0) ? w_cur_max : w_cur_dig - 4'd1;

    always_ff @(posedge clkin) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            r_preload <= '0;
            r_cursor  <= '0;
            r_psc     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_count   <= w_count_nxt;
            r_preload <= w_preload_nxt;
            r_cursor  <= w_cursor_nxt;
            r_psc     <= w_psc_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_count_nxt   = r_count;
        w_preload_nxt = r_preload;
        w_cursor_nxt  = r_cursor;
        w_psc_nxt     = r_psc;
        case (r_state)
            S_IDLE: begin
                if (w_ev_e) begin
                    w_state_nxt  = S_SET;
                    w_count_nxt  = r_preload;
                    w_cursor_nxt = '0;
                end
            end
            S_SET: begin
                if (w_ev_e) begin
                    w_preload_nxt = r_count;
                    w_psc_nxt     = '0;
                    w_state_nxt   = (r_count == '0) ? S_DONE : S_RUN;
                end else if (w_ev_u) begin
                    w_count_nxt[int'(r_cursor)*4 +: 4] = w_dig_inc;
                end else if (w_ev_d) begin
                    w_count_nxt[int'(r_cursor)*4 +: 4] = w_dig_dec;
                end else if (w_ev_r) begin
                    w_cursor_nxt = (r_cursor == '0) ? C_LAST : r_cursor - 1'b1;
                end else if (w_ev_l) begin
                    w_cursor_nxt = (r_cursor == C_LAST) ? '0 : r_cursor + 1'b1;
                end
            end
            S_RUN: begin
                if (r_count == '0) begin
                    w_state_nxt = S_DONE;
                end else if (w_ev_e) begin
                    w_state_nxt = S_PAUSE;
                end else if (r_psc == C_TICK_LAST) begin
                    w_psc_nxt   = '0;
                    w_count_nxt = w_count_dec;
                end else begin
                    w_psc_nxt = r_psc + 1'b1;
                end
            end
            S_PAUSE: begin
                if (w_ev_e) begin
                    w_state_nxt = S_RUN;
                end else if (w_ev_d) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_DONE: begin
                if (w_ev_e) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    logic [CW-1:0]        r_scan;
    logic [SW-1:0]        r_scp;
    logic [BW-1:0]        r_blk;
    logic                 r_blink;
    logic [N_DIG-1:0]     r_sel;
    logic [7:0]           r_led;
    logic [4*N_DIG-1:0]   w_src;
    logic [7:0]           w_glyph;

    always_comb begin
        w_src   = (r_state == S_IDLE) ? r_preload : r_count;
        w_glyph = seg7(w_src[int'(r_scan)*4 +: 4]);
        if (r_state == S_DONE) begin
            case (int'(r_scan))
                2:       w_glyph = 8'h86;
                1:       w_glyph = 8'hAB;
                0:       w_glyph = 8'hA1;
                default: w_glyph = 8'hFF;
            endcase
        end else if (r_state == S_SET && r_blink && r_scan == r_cursor) begin
            w_glyph = 8'hFF;
        end
    end

    // sel and led are loaded from the same scan index on the same edge
    always_ff @(posedge clkin) begin
        if (!rst_n) begin
            r_scan  <= '0;
            r_scp   <= '0;
            r_blk   <= '0;
            r_blink <= 1'b0;
            r_sel   <= '1;
            r_led   <= 8'hFF;
        end else begin
            if (r_scp == C_SCAN_LAST) begin
                r_scp  <= '0;
                r_scan <= (r_scan == '0) ? C_LAST : r_scan - 1'b1;
            end else begin
                r_scp <= r_scp + 1'b1;
            end
            if (r_blk == C_BLINK_LAST) begin
                r_blk   <= '0;
                r_blink <= !r_blink;
            end else begin
                r_blk <= r_blk + 1'b1;
            end
            r_sel <= ~(N_DIG'(1) << r_scan);
            r_led <= w_glyph;
        end
    end

    assign bus.sel     = r_sel;
    assign bus.led     = r_led;
    assign bus.alarm   = (r_state != S_DONE);
    assign bus.state_o = r_state;
    assign bus.bcd_o   = (r_state == S_IDLE) ? r_preload :
                         (r_state == S_DONE) ? '0 : r_count;
endmodule
`default_nettype wire

// File: tb/tb_countdown_timer_gen2.sv
`default_nettype none
// ============================================================================
// tb_countdown_timer_gen2 : random and directed key stimulus on a decimal and
//                           a base-60 instance, checked against a digit model
// Revision: 1.0
// ============================================================================
module tb_countdown_timer_gen2;
    localparam int N = 6, DEB = 4, TICK = 10, SCAN = 2, BLINK = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] kb = 5'h1F;   // bit0 ke, bit1 ku, bit2 kd, bit3 kr, bit4 kl
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    countdown_timer_gen2_if #(.N_DIG(N)) bus0 ();
    countdown_timer_gen2_if #(.N_DIG(N)) bus1 ();

    assign bus0.ke = kb[0]; assign bus0.ku = kb[1]; assign bus0.kd = kb[2];
    assign bus0.kr = kb[3]; assign bus0.kl = kb[4];
    assign bus1.ke = kb[0]; assign bus1.ku = kb[1]; assign bus1.kd = kb[2];
    assign bus1.kr = kb[3]; assign bus1.kl = kb[4];

    countdown_timer_gen2 #(.N_DIG(N), .DEB_CYC(DEB), .TICK_CYC(TICK), .SCAN_CYC(SCAN),
                           .BLINK_CYC(BLINK), .SEXA(0))
        dut0 (.clkin(clk), .rst_n(rst_n), .bus(bus0));
    countdown_timer_gen2 #(.N_DIG(N), .DEB_CYC(DEB), .TICK_CYC(TICK), .SCAN_CYC(SCAN),
                           .BLINK_CYC(BLINK), .SEXA(1))
        dut1 (.clkin(clk), .rst_n(rst_n), .bus(bus1));

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (unit 0 decimal, unit 1 base-60) ----------------
    int         m_state[2], m_cur[2], m_psc[2];
    int         m_cnt[2][N], m_pre[2][N];
    int         m_n;
    int         low_run[5];
    logic [4:0] h1, h2;
    logic [5:0] e_sel[2];
    logic [7:0] e_led[2];
    bit         m_valid = 0;

    function automatic int radix(input int u, input int i);
        return (u == 1 && (i % 2) == 1) ? 6 : 10;
    endfunction

    function automatic int value(input int u);
        int v = 0;
        for (int i = N - 1; i >= 0; i--) v = v * radix(u, i) + m_cnt[u][i];
        return v;
    endfunction

    function automatic void set_value(input int u, input int v);
        for (int i = 0; i < N; i++) begin
            m_cnt[u][i] = v % radix(u, i);
            v = v / radix(u, i);
        end
    endfunction

    function automatic logic [7:0] glyph(input int d);
        logic [7:0] tbl [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
        return tbl[d];
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int u = 0; u < 2; u++) begin
                m_state[u] = 0; m_cur[u] = 0; m_psc[u] = 0;
                for (int i = 0; i < N; i++) begin m_cnt[u][i] = 0; m_pre[u][i] = 0; end
                e_sel[u] = 6'h3F; e_led[u] = 8'hFF;
            end
            for (int k = 0; k < 5; k++) low_run[k] = 0;
            h1 = 5'h1F; h2 = 5'h1F; m_n = 0; m_valid = 1;
        end else begin
            int idx, blink, evk;
            logic [4:0] ev;
            idx   = (N - (m_n / SCAN) % N) % N;
            blink = (m_n / BLINK) % 2;
            for (int u = 0; u < 2; u++) begin
                e_sel[u] = ~(6'b1 << idx);
                if (m_state[u] == 4)
                    e_led[u] = (idx == 2) ? 8'h86 : (idx == 1) ? 8'hAB : (idx == 0) ? 8'hA1 : 8'hFF;
                else if (m_state[u] == 1 && blink == 1 && idx == m_cur[u])
                    e_led[u] = 8'hFF;
                else
                    e_led[u] = glyph(m_state[u] == 0 ? m_pre[u][idx] : m_cnt[u][idx]);
            end
            // a release qualifies after at least DEB synchronised low samples
            ev = '0;
            for (int k = 0; k < 5; k++) begin
                if (h2[k] && low_run[k] >= DEB) ev[k] = 1'b1;
                low_run[k] = h2[k] ? 0 : low_run[k] + 1;
            end
            h2 = h1; h1 = kb;
            evk = -1;
            for (int k = 4; k >= 0; k--) if (ev[k]) evk = k;
            for (int u = 0; u < 2; u++) begin
                case (m_state[u])
                    0: if (evk == 0) begin
                        m_state[u] = 1; m_cur[u] = 0;
                        for (int i = 0; i < N; i++) m_cnt[u][i] = m_pre[u][i];
                    end
                    1: begin
                        int c, r;
                        c = m_cur[u]; r = radix(u, c);
                        if (evk == 0) begin
                            for (int i = 0; i < N; i++) m_pre[u][i] = m_cnt[u][i];
                            m_psc[u] = 0;
                            m_state[u] = (value(u) == 0) ? 4 : 2;
                        end else if (evk == 1) m_cnt[u][c] = (m_cnt[u][c] + 1) % r;
                        else if (evk == 2) m_cnt[u][c] = (m_cnt[u][c] + r - 1) % r;
                        else if (evk == 3) m_cur[u] = (c + N - 1) % N;
                        else if (evk == 4) m_cur[u] = (c + 1) % N;
                    end
                    2: begin
                        if (value(u) == 0) m_state[u] = 4;
                        else if (evk == 0) m_state[u] = 3;
                        else if (m_psc[u] == TICK - 1) begin
                            m_psc[u] = 0;
                            set_value(u, value(u) - 1);
                        end else m_psc[u] = m_psc[u] + 1;
                    end
                    3: if (evk == 0) m_state[u] = 2; else if (evk == 2) m_state[u] = 0;
                    4: if (evk == 0) m_state[u] = 0;
                    default: m_state[u] = 0;
                endcase
            end
            m_n++;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            logic [5:0]  a_sel[2];
            logic [7:0]  a_led[2];
            logic        a_alarm[2];
            logic [2:0]  a_state[2];
            logic [23:0] a_bcd[2];
            a_sel[0] = bus0.sel; a_led[0] = bus0.led; a_alarm[0] = bus0.alarm;
            a_state[0] = bus0.state_o; a_bcd[0] = bus0.bcd_o;
            a_sel[1] = bus1.sel; a_led[1] = bus1.led; a_alarm[1] = bus1.alarm;
            a_state[1] = bus1.state_o; a_bcd[1] = bus1.bcd_o;
            for (int u = 0; u < 2; u++) begin
                logic [23:0] eb;
                eb = '0;
                for (int i = 0; i < N; i++)
                    eb[4*i +: 4] = (m_state[u] == 0) ? 4'(m_pre[u][i]) :
                                   (m_state[u] == 4) ? 4'd0 : 4'(m_cnt[u][i]);
                check($sformatf("u%0d state", u), 32'(a_state[u]), 32'(m_state[u]));
                check($sformatf("u%0d bcd", u), 32'(a_bcd[u]), 32'(eb));
                check($sformatf("u%0d alarm", u), 32'(a_alarm[u]), (m_state[u] == 4) ? 32'd0 : 32'd1);
                check($sformatf("u%0d sel", u), 32'(a_sel[u]), 32'(e_sel[u]));
                check($sformatf("u%0d led", u), 32'(a_led[u]), 32'(e_led[u]));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic press(input logic [4:0] m, input int len, input int gap);
        @(negedge clk);
        kb = 5'h1F & ~m;
        repeat (len) @(negedge clk);
        kb = 5'h1F;
        repeat (gap) @(negedge clk);
    endtask

    localparam logic [4:0] KE = 5'd1, KU = 5'd2, KD = 5'd4, KR = 5'd8, KL = 5'd16;

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset sel", 32'(bus0.sel), 32'h3F);
        check("reset led", 32'(bus0.led), 32'hFF);
        check("reset alarm", 32'(bus0.alarm), 32'h1);
        check("reset state", 32'(bus0.state_o), 32'h0);
        rst_n = 1'b1;

        press(KE, 6, 6);
        check("enter set", 32'(bus0.state_o), 32'h1);
        press(KU, 2, 6);
        check("glitch ignored", 32'(bus0.bcd_o), 32'h0);
        press(KU, 6, 6);
        check("one increment", 32'(bus0.bcd_o), 32'h000001);
        press(KU, 5, 6); press(KU, 5, 6); press(KL, 5, 6); press(KU, 5, 6);
        press(KE, 5, 6);
        check("run 13 count", 32'(bus0.bcd_o), 32'h000013);
        check("run 13 state", 32'(bus0.state_o), 32'h2);
        for (int i = 0; i < 300 && bus0.state_o != 3'd4; i++) @(negedge clk);
        check("reach done", 32'(bus0.state_o), 32'h4);
        check("done alarm", 32'(bus0.alarm), 32'h0);
        check("done alarm sexa", 32'(bus1.alarm), 32'h0);
        press(KE, 5, 6);
        check("idle preload", 32'(bus0.bcd_o), 32'h000013);

        press(KE, 5, 6);
        press(KD, 5, 6); press(KD, 5, 6); press(KD, 5, 6);
        press(KL, 5, 6); press(KD, 5, 6);
        press(KL, 5, 6); press(KU, 5, 6);
        check("set 100", 32'(bus0.bcd_o), 32'h000100);
        press(KE, 5, 0);
        for (int i = 0; i < 40 && bus0.bcd_o == 24'h000100; i++) @(negedge clk);
        check("borrow dec", 32'(bus0.bcd_o), 32'h000099);
        check("borrow sexa", 32'(bus1.bcd_o), 32'h000059);

        press(KE, 5, 6);
        check("pause", 32'(bus0.state_o), 32'h3);
        repeat (50) @(negedge clk);
        check("pause frozen", 32'(bus0.bcd_o), 32'h000099);
        press(KE, 5, 6);
        check("resume", 32'(bus0.state_o), 32'h2);
        press(KE, 5, 6);
        press(KD, 5, 6);
        check("abort idle", 32'(bus0.state_o), 32'h0);
        check("abort preload", 32'(bus0.bcd_o), 32'h000100);

        press(KE, 5, 6);
        press(KL, 5, 6); press(KL, 5, 6); press(KD, 5, 6);
        press(KE, 5, 6);
        check("zero done", 32'(bus0.state_o), 32'h4);
        for (int i = 0; i < 12; i++) begin
            logic [7:0] lit;
            @(negedge clk);
            case (bus0.sel)
                6'h3B:   lit = 8'h86;
                6'h3D:   lit = 8'hAB;
                6'h3E:   lit = 8'hA1;
                default: lit = 8'hFF;
            endcase
            check("end glyph", 32'(bus0.led), 32'(lit));
        end

        press(KE, 5, 6);
        press(KE, 5, 6);
        press(KU | KD, 6, 6);
        check("ku beats kd", 32'(bus0.bcd_o), 32'h000001);
        repeat (4) press(KU, 5, 6);
        press(KE, 5, 3);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrun rst state", 32'(bus0.state_o), 32'h0);
        check("midrun rst alarm", 32'(bus0.alarm), 32'h1);
        check("midrun rst led", 32'(bus0.led), 32'hFF);
        check("midrun rst bcd", 32'(bus0.bcd_o), 32'h0);
        rst_n = 1'b1;

        for (int it = 0; it < 250; it++) begin
            logic [4:0] m;
            m = 5'(1 << $urandom_range(0, 4));
            if ($urandom_range(0, 4) == 0) m = m | 5'(1 << $urandom_range(0, 4));
            press(m, $urandom_range(1, 7), $urandom_range(1, 25));
        end

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
